counter_sync_param: RTL and testbench



---
 rtl/counter_pkg.sv | 13 +
 rtl/counter_sync_param_if.sv | 29 ++
 rtl/counter_next.sv | 49 ++++
 rtl/counter_sync_param.sv | 70 +++++++
 tb/tb_counter_sync_param.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the parametrised cascadable counter.
// Direction encodings and the WIDTH-bit terminal constant helper.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Terminal count; caller truncates to WIDTH so MODULUS == 2**WIDTH stays safe
    function automatic int unsigned term_const(input int unsigned modulus);
        return modulus - 1;
    endfunction

endpackage

// File: rtl/counter_sync_param_if.sv
// Control/status bundle of counter_sync_param.
// master drives controls and load data; slave is the counter side.
interface counter_sync_param_if #(
    parameter int WIDTH = 4
);

    logic             sclr_n;
    logic             load_n;
    logic             enp;
    logic             ent;
    logic             up;
    logic             clr_ovf;
    logic [WIDTH-1:0] P;
    logic [WIDTH-1:0] Q;
    logic             rco;
    logic             wrap_q;
    logic             ovf;

    modport master (
        output sclr_n, load_n, enp, ent, up, clr_ovf, P,
        input  Q, rco, wrap_q, ovf
    );

    modport slave (
        input  sclr_n, load_n, enp, ent, up, clr_ovf, P,
        output Q, rco, wrap_q, ovf
    );

endinterface

// File: rtl/counter_next.sv
// Next-count, wrap and terminal computation for counter_sync_param.
// Down counting exists only when COUNTER_UPDOWN_EN is defined.
module counter_next
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 2 ** WIDTH
) (
    input  logic [WIDTH-1:0] q_i,
`ifdef COUNTER_UPDOWN_EN
    input  logic             up_i,
`endif
    output logic [WIDTH-1:0] nxt_o,
    output logic             wrap_o,
    output logic             term_o
);

    localparam logic [WIDTH-1:0] TERM = WIDTH'(term_const(MODULUS));

    logic             t_up;
    logic [WIDTH-1:0] n_up;

    assign t_up = (q_i >= TERM);
    assign n_up = t_up ? '0 : q_i + WIDTH'(1);

`ifdef COUNTER_UPDOWN_EN
    logic             t_dn;
    logic [WIDTH-1:0] n_dn;

    // Out-of-range loads just walk down until they reach the sequence
    assign t_dn = (q_i == '0);
    assign n_dn = t_dn ? TERM : q_i - WIDTH'(1);

    always_comb begin
        term_o = t_up;
        nxt_o  = n_up;
        if (up_i == DIR_DOWN) begin
            term_o = t_dn;
            nxt_o  = n_dn;
        end
    end
`else
    assign term_o = t_up;
    assign nxt_o  = n_up;
`endif

    assign wrap_o = term_o;

endmodule

// File: rtl/counter_sync_param.sv
// Cascadable synchronous counter, 74163-style rco; registered wrap/ovf.
// Define COUNTER_UPDOWN_EN to honour the up input (default: up-only).
module counter_sync_param
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 2 ** WIDTH
) (
    input logic                  clk,
    input logic                  clr_n,
    counter_sync_param_if.slave  bus
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             pulse_q, pulse_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] nxt;
    logic             wrap;
    logic             term;
    logic             step;

    counter_next #(
        .WIDTH  (WIDTH),
        .MODULUS(MODULUS)
    ) u_next (
        .q_i   (q_q),
`ifdef COUNTER_UPDOWN_EN
        .up_i  (bus.up),
`endif
        .nxt_o (nxt),
        .wrap_o(wrap),
        .term_o(term)
    );

    assign step = bus.enp & bus.ent;

    always_comb begin
        q_d     = q_q;
        pulse_d = 1'b0;
        priority case (1'b1)
            !bus.sclr_n: q_d = '0;
            !bus.load_n: q_d = bus.P;
            step: begin
                q_d     = nxt;
                pulse_d = wrap;
            end
            default: q_d = q_q;
        endcase
        // A wrap on the same edge as clr_ovf keeps the flag set
        ovf_d = pulse_d | (ovf_q & ~bus.clr_ovf);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q_q     <= '0;
            pulse_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            q_q     <= q_d;
            pulse_q <= pulse_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.Q      = q_q;
    assign bus.rco    = bus.ent & term;
    assign bus.wrap_q = pulse_q;
    assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_counter_sync_param.sv
// Scoreboard bench: MODULUS=10 counter plus a cascaded pair of MODULUS=16.
module tb_counter_sync_param;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

`ifdef COUNTER_UPDOWN_EN
    localparam bit UD = 1'b1;
`else
    localparam bit UD = 1'b0;
`endif

    counter_sync_param_if #(.WIDTH(4)) bus ();
    counter_sync_param_if #(.WIDTH(4)) blo ();
    counter_sync_param_if #(.WIDTH(4)) bhi ();

    counter_sync_param #(.WIDTH(4), .MODULUS(10)) dut (
        .clk(clk), .clr_n(clr_n), .bus(bus.slave));
    counter_sync_param #(.WIDTH(4), .MODULUS(16)) u_lo (
        .clk(clk), .clr_n(clr_n), .bus(blo.slave));
    counter_sync_param #(.WIDTH(4), .MODULUS(16)) u_hi (
        .clk(clk), .clr_n(clr_n), .bus(bhi.slave));

    assign bhi.ent = blo.rco;
    assign bhi.enp = blo.enp;

    typedef struct {
        int         tgt;
        int         id;
        string      nm;
        logic [7:0] q;
        logic [1:0] r;
        logic [1:0] w;
        logic [1:0] o;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [7:0] aq;
    logic [1:0] ar, aw, ao;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input string f,
                       input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %0h want %0h", nm, f, act, exp);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].tgt <= cyc) begin
            me = sb.pop_front();
            if (me.id == 0) begin
                aq = {4'h0, bus.Q};
                ar = {1'b0, bus.rco};
                aw = {1'b0, bus.wrap_q};
                ao = {1'b0, bus.ovf};
            end else begin
                aq = {bhi.Q, blo.Q};
                ar = {bhi.rco, blo.rco};
                aw = {bhi.wrap_q, blo.wrap_q};
                ao = {bhi.ovf, blo.ovf};
            end
            chk(me.nm, "Q", aq, me.q);
            chk(me.nm, "rco", {6'd0, ar}, {6'd0, me.r});
            chk(me.nm, "wrap_q", {6'd0, aw}, {6'd0, me.w});
            chk(me.nm, "ovf", {6'd0, ao}, {6'd0, me.o});
        end
    end

    task automatic push(input int tgt, input int id, input string nm,
                        input logic [7:0] q, input logic [1:0] r,
                        input logic [1:0] w, input logic [1:0] o);
        exp_t e;
        e.tgt = tgt; e.id = id; e.nm = nm;
        e.q = q; e.r = r; e.w = w; e.o = o;
        sb.push_back(e);
    endtask

    task automatic vec(input logic s, input logic l, input logic pe,
                       input logic te, input logic u, input logic co,
                       input logic [3:0] p, input string nm,
                       input logic [3:0] q, input logic r,
                       input logic w, input logic o);
        @(negedge clk);
        #1;
        clr_n       = 1'b1;
        bus.sclr_n  = s;
        bus.load_n  = l;
        bus.enp     = pe;
        bus.ent     = te;
        bus.up      = u;
        bus.clr_ovf = co;
        bus.P       = p;
        push(cyc + 1, 0, nm, {4'h0, q}, {1'b0, r}, {1'b0, w}, {1'b0, o});
    endtask

    task automatic cvec(input logic s, input logic l, input logic pe,
                        input logic [7:0] p, input string nm,
                        input logic [7:0] q, input logic [1:0] r,
                        input logic [1:0] w, input logic [1:0] o);
        @(negedge clk);
        #1;
        clr_n      = 1'b1;
        blo.sclr_n = s;
        bhi.sclr_n = s;
        blo.load_n = l;
        bhi.load_n = l;
        blo.enp    = pe;
        blo.P      = p[3:0];
        bhi.P      = p[7:4];
        push(cyc + 1, 1, nm, q, r, w, o);
    endtask

    task automatic async_rst();
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #2;
        bus.enp = 1'b1;
        bus.ent = 1'b1;
        clr_n   = 1'b0;
        push(cyc, 0, "async", 8'h00, 2'b00, 2'b00, 2'b00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sclr_n = 1; bus.load_n = 1; bus.enp = 0; bus.ent = 1;
        bus.up = 1; bus.clr_ovf = 0; bus.P = '0;
        blo.sclr_n = 1; blo.load_n = 1; blo.enp = 0; blo.ent = 1;
        blo.up = 1; blo.clr_ovf = 0; blo.P = '0;
        bhi.sclr_n = 1; bhi.load_n = 1;
        bhi.up = 1; bhi.clr_ovf = 0; bhi.P = '0;
        push(0, 0, "rst", 8'h00, 2'b00, 2'b00, 2'b00);
        push(0, 1, "crst", 8'h00, 2'b00, 2'b00, 2'b00);

        for (int i = 1; i <= 9; i++)
            vec(1, 1, 1, 1, 1, 0, 0, "up", 4'(i), i == 9, 0, 0);
        vec(1, 1, 1, 0, 1, 0, 0, "ent0", 9, 0, 0, 0);
        vec(1, 1, 1, 1, 1, 0, 0, "wrap9", 0, 0, 1, 1);
        vec(1, 1, 0, 1, 1, 0, 0, "hold", 0, 0, 0, 1);
        vec(1, 0, 1, 1, 1, 0, 12, "ld12", 12, 1, 0, 1);
        vec(1, 1, 1, 1, 1, 0, 0, "12to0", 0, 0, 1, 1);
        vec(1, 1, 0, 1, 1, 1, 0, "clrovf", 0, 0, 0, 0);
        vec(0, 0, 1, 1, 1, 0, 5, "sclr_ld", 0, 0, 0, 0);
        vec(1, 0, 1, 1, 1, 0, 5, "ld5", 5, 0, 0, 0);
        vec(1, 0, 0, 1, 1, 0, 9, "ld9", 9, 1, 0, 0);
        vec(1, 1, 1, 1, 1, 1, 0, "setwins", 0, 0, 1, 1);
        vec(1, 1, 0, 1, 1, 1, 0, "clrovf2", 0, 0, 0, 0);
        vec(1, 0, 0, 1, 1, 0, 9, "ld9b", 9, 1, 0, 0);
        vec(1, 1, 1, 1, 1, 0, 0, "wrapb", 0, 0, 1, 1);
        for (int i = 1; i <= 7; i++)
            vec(1, 1, 1, 1, 1, 0, 0, "to7", 4'(i), 0, 0, 1);
        vec(1, 1, 0, 1, 1, 0, 0, "hold7", 7, 0, 0, 1);
        async_rst();
        vec(1, 1, 1, 1, 1, 0, 0, "postrst", 1, 0, 0, 0);

        vec(0, 1, 1, 1, 0, 0, 0, "sclr_dn", 0, UD, 0, 0);
        vec(1, 1, 1, 1, 0, 0, 0, "dn1", UD ? 4'd9 : 4'd1, 0, UD, UD);
        vec(1, 1, 1, 1, 0, 0, 0, "dn2", UD ? 4'd8 : 4'd2, 0, 0, UD);
        vec(1, 0, 0, 1, 1, 0, 0, "ld0up", 0, 0, 0, UD);

        for (int i = 1; i <= 17; i++)
            cvec(1, 1, 1, 8'h00, "casc", 8'(i), {1'b0, i % 16 == 15},
                 {1'b0, i == 16}, {1'b0, i >= 16});
        cvec(1, 0, 1, 8'hFE, "cld", 8'hFE, 2'b00, 2'b00, 2'b01);
        cvec(1, 1, 1, 8'h00, "c255", 8'hFF, 2'b11, 2'b00, 2'b01);
        cvec(1, 1, 1, 8'h00, "cwrap", 8'h00, 2'b00, 2'b11, 2'b11);
        cvec(1, 1, 0, 8'h00, "chold", 8'h00, 2'b00, 2'b00, 2'b11);

        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
